trig_scheduler: RTL
===================

TRIG_SCHEDULER -- requirements
Module: trig_scheduler

Interface
REQ-001 SHALL have parameter NBUF, default 4, number of readout event buffers (power of 2, 2..16).
REQ-002 SHALL have parameter HOLDOFF, default 64, minimum aclk cycles between accepted triggers (used only under TRIG_HOLDOFF_EN).
REQ-003 SHALL have port aclk_i  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run_rst_i  input  1  pulse: clear counters and start a run.
REQ-006 SHALL have port run_stop_i  input  1  pulse: stop accepting triggers.
REQ-007 SHALL have port trig_time_i  input  16  trigger time, qualified by trig_time_valid_i.
REQ-008 SHALL have port trig_time_valid_i  input  1  single-cycle trigger request.
REQ-009 SHALL have port buf_done_i  input  1  pulse: readout has freed one event buffer.
REQ-010 SHALL have port m_axis_tdata  output  32  {event_no[15:0], trig_time[15:0]} to the memory readout.
REQ-011 SHALL have port m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-012 SHALL have port m_axis_tready  input  1  AXI4-Stream ready.
REQ-013 SHALL have port running_o  output  1  high in RUN state.
REQ-014 SHALL have port busy_o  output  1  high when zero buffers are free.
REQ-015 SHALL have port trig_num_o  output  16  next event number (count of accepted triggers).
REQ-016 SHALL have port drop_cnt_o  output  16  triggers rejected while in RUN.

Function
REQ-017 SHALL implement states STOPPED, RUN, DRAIN.
REQ-018 SHALL transition from any state to RUN on run_rst_i: trig_num and drop_cnt cleared, queue flushed, free count loaded with NBUF.
REQ-019 SHALL, on run_stop_i in RUN, go to DRAIN if the queue is non-empty, else to STOPPED; when asserted together with run_rst_i, counters clear and state is STOPPED.
REQ-020 SHALL leave DRAIN for STOPPED in the cycle after the queue becomes empty; DRAIN still presents queued entries.
REQ-021 SHALL accept a trigger when state is RUN, free count > 0 and holdoff is expired: push {trig_num, trig_time_i}, increment trig_num (16-bit wrap), decrement free count.
REQ-022 SHALL, for a trigger in RUN that is not accepted, increment drop_cnt, saturating at 0xFFFF.
REQ-023 SHALL ignore triggers in STOPPED and DRAIN without counting them.
REQ-024 SHALL hold the queue depth at NBUF so that free count > 0 guarantees space.
REQ-025 SHALL leave free count unchanged on a simultaneous accept and buf_done_i; SHALL ignore buf_done_i when free count equals NBUF.
REQ-026 SHALL assert m_axis_tvalid one cycle after acceptance into an empty queue, and SHALL keep tdata stable while tvalid is high and tready is low.
REQ-027 SHALL pop one entry per cycle with tvalid and tready both high, with no bubbles under back-to-back entries.
REQ-028 SHALL drive busy_o from the registered free count == 0.

Reset
REQ-029 SHALL, with aresetn_i low, force STOPPED, empty queue, free count NBUF, holdoff expired, m_axis_tvalid 0, m_axis_tdata 0, running_o 0, busy_o 0, trig_num_o 0, drop_cnt_o 0.
REQ-030 SHALL discard queued entries on reset mid-operation; no tvalid appears until a new accept.

Configuration
REQ-031 SHALL, with TRIG_HOLDOFF_EN defined, load a down-counter with HOLDOFF-1 on each accept and reject (count as dropped) triggers while it is non-zero.
REQ-032 SHALL, without TRIG_HOLDOFF_EN, contain no holdoff counter and treat holdoff as always expired; HOLDOFF is unused.

Structure
REQ-033 SHALL take the state enum, the default NBUF and the packed tdata struct (event_no, trig_time) from shared package pueo_trig_pkg.
REQ-034 SHALL implement the queue as sub-module trig_sched_fifo (synchronous, first-word-fall-through, depth NBUF, width 32).

Verification
REQ-035 SHALL cover: run_rst, 3 triggers (times 0x0100, 0x0200, 0x0300) with tready=1 -> tdata 0x00000100, 0x00010200, 0x00020300; trig_num_o=3.
REQ-036 SHALL cover: NBUF=4, tready=0, 6 triggers spaced apart -> 4 queued, busy_o=1, drop_cnt_o=2; one buf_done_i then a trigger -> accepted as event_no 4.
REQ-037 SHALL cover: trigger and buf_done_i in the same cycle with free=1 -> accepted, free stays 1, busy_o=0.
REQ-038 SHALL cover: 2 queued entries, run_stop_i -> DRAIN, both delivered once tready=1, then STOPPED; a trigger in DRAIN is not counted.
REQ-039 SHALL cover: TRIG_HOLDOFF_EN with HOLDOFF=64, triggers at cycles 0, 10 and 64 -> cycles 0 and 64 accepted, drop_cnt_o=1; without the macro all three are accepted.
REQ-040 SHALL cover: aresetn_i low while tvalid is high with 3 entries queued -> tvalid 0 immediately, all outputs at reset values, state STOPPED.

Source files
------------

// File: rtl/pueo_trig_pkg.sv
// pueo_trig_pkg: shared state enum, default buffer count and readout word layout for the trigger scheduler
package pueo_trig_pkg;
  localparam int NBUF_DEFAULT = 4;
  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2
  } trig_state_t;
  typedef struct packed {
    logic [15:0] event_no;
    logic [15:0] trig_time;
  } trig_tdata_t;
endpackage

// File: rtl/trig_sched_fifo.sv
// trig_sched_fifo: synchronous first-word-fall-through queue, head word driven to zero while empty
module trig_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             aclk_i,
  input  logic             aresetn_i,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr, rd;
  assign wr = wr_en && count != (AW+1)'(DEPTH);
  assign rd = rd_en && not_empty;
  assign not_empty = count != '0;
  assign rd_data = not_empty ? mem[rd_ptr] : '0;
  // pointer and occupancy bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  // storage needs no reset because the head is gated by occupancy
  always_ff @(posedge aclk_i) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/trig_scheduler.sv
// trig_scheduler: accepts triggers against free readout buffers and streams {event_no, trig_time}; TRIG_HOLDOFF_EN adds a minimum trigger spacing
module trig_scheduler
  import pueo_trig_pkg::*;
#(
  parameter int NBUF    = NBUF_DEFAULT,
  parameter int HOLDOFF = 64
) (
  input  logic        aclk_i,
  input  logic        aresetn_i,
  input  logic        run_rst_i,
  input  logic        run_stop_i,
  input  logic [15:0] trig_time_i,
  input  logic        trig_time_valid_i,
  input  logic        buf_done_i,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        running_o,
  output logic        busy_o,
  output logic [15:0] trig_num_o,
  output logic [15:0] drop_cnt_o
);
  localparam int FW = $clog2(NBUF) + 1;
  localparam logic [FW-1:0] FREE_MAX = FW'(NBUF);
  if (NBUF < 2 || NBUF > 16 || (NBUF & (NBUF - 1)) != 0) begin : g_bad_nbuf
    $error("trig_scheduler: NBUF must be a power of 2 in 2..16");
  end
  if (HOLDOFF < 1) begin : g_bad_holdoff
    $error("trig_scheduler: HOLDOFF must be at least 1");
  end
  trig_state_t state, state_nx;
  logic [FW-1:0] free_cnt;
  logic [15:0] trig_num, drop_cnt;
  logic hold_ok, acc, rej, buf_inc, fifo_valid;
  trig_tdata_t entry;
  assign acc = trig_time_valid_i && !run_rst_i && state == ST_RUN && free_cnt != '0 && hold_ok;
  assign rej = trig_time_valid_i && !run_rst_i && state == ST_RUN && !acc;
  assign buf_inc = buf_done_i && free_cnt != FREE_MAX;
  assign entry = {trig_num, trig_time_i};
  assign running_o = state == ST_RUN;
  assign busy_o = free_cnt == '0;
  assign trig_num_o = trig_num;
  assign drop_cnt_o = drop_cnt;
  assign m_axis_tvalid = fifo_valid;
`ifdef TRIG_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 1);
  logic [HW-1:0] hold_cnt;
  // holdoff window restarts on every accepted trigger
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) hold_cnt <= '0;
    else if (run_rst_i) hold_cnt <= '0;
    else if (acc) hold_cnt <= HW'(HOLDOFF - 1);
    else if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
  end
  assign hold_ok = hold_cnt == '0;
`else
  assign hold_ok = 1'b1;
`endif
  // run control state register
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) state <= ST_STOPPED;
    else state <= state_nx;
  end
  // run/stop/drain sequencing; a trigger accepted with the stop still needs draining
  always_comb begin
    state_nx = state;
    if (run_rst_i) state_nx = run_stop_i ? ST_STOPPED : ST_RUN;
    else if (state == ST_RUN && run_stop_i) state_nx = (fifo_valid || acc) ? ST_DRAIN : ST_STOPPED;
    else if (state == ST_DRAIN && !fifo_valid) state_nx = ST_STOPPED;
  end
  // free-buffer accounting plus event and drop counters
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      free_cnt <= FREE_MAX;
      trig_num <= '0;
      drop_cnt <= '0;
    end else if (run_rst_i) begin
      free_cnt <= FREE_MAX;
      trig_num <= '0;
      drop_cnt <= '0;
    end else begin
      free_cnt <= free_cnt - FW'(acc) + FW'(buf_inc);
      if (acc) trig_num <= trig_num + 16'd1;
      if (rej && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  trig_sched_fifo #(.DEPTH(NBUF), .WIDTH(32)) u_fifo (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .flush     (run_rst_i),
    .wr_en     (acc),
    .wr_data   (entry),
    .rd_en     (m_axis_tready),
    .rd_data   (m_axis_tdata),
    .not_empty (fifo_valid)
  );
endmodule
